// File: rtl/io_port_controller_pkg.sv
// Shared types and constants for the processor I/O port controller.
// Interrupt FSM encodings are fixed so they can be matched against processor-side decoding.
package io_port_controller_pkg;

    localparam int unsigned IOC_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StWait  = 2'd2
    } ioc_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a combinational head word.
// When full, a push is still taken if a pop frees the slot in the same cycle.
module io_sync_fifo
    import io_port_controller_pkg::*;
#(
    parameter int unsigned DATA_W = IOC_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = do_push ? wptr_q + PtrOne : wptr_q;
        rptr_d = do_pop  ? rptr_q + PtrOne : rptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are only visible through non-empty pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// Device-side partner of the processor In/Out/Int pins: RX FIFO feeding proc_in with an
// interrupt pulse FSM, TX FIFO collecting OUT writes with a sticky overflow flag.
module io_port_controller
    import io_port_controller_pkg::*;
#(
    parameter int unsigned DATA_W    = IOC_DATA_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned INT_PULSE = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic [DATA_W-1:0] proc_in,
    input  logic              proc_in_rd,
    input  logic [DATA_W-1:0] proc_out,
    input  logic              proc_out_we,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    output logic              int_req,
    output logic              tx_drop
);

    localparam int unsigned CntW = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(INT_PULSE - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic [DATA_W-1:0] rx_head;
    logic              tx_full, tx_empty, tx_pop;

    ioc_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pop_seen_q, pop_seen_d;
    logic              tx_drop_q, tx_drop_d;

    assign dev_in_ready  = !rx_full;
    assign rx_push       = dev_in_valid && !rx_full;
    assign rx_pop        = proc_in_rd && !rx_empty;
    assign proc_in       = rx_empty ? '0 : rx_head;

    assign dev_out_valid = !tx_empty;
    assign tx_pop        = dev_out_valid && dev_out_ready;
    assign tx_drop       = tx_drop_q;

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (rx_push),
        .data_i  (dev_in_data),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (proc_out_we),
        .data_i  (proc_out),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (dev_out_data)
    );

    assign tx_drop_d = tx_drop_q || (proc_out_we && tx_full && !tx_pop);

    // A pop during the pulse is remembered so WAIT does not stall for a second pop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pop_seen_d = pop_seen_q;
        int_req    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_empty) begin
                    state_d    = StPulse;
                    cnt_d      = CntLoad;
                    pop_seen_d = 1'b0;
                end
            end
            StPulse: begin
                int_req = 1'b1;
                if (rx_pop) begin
                    pop_seen_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWait: begin
                if (rx_pop || pop_seen_q) begin
                    state_d    = StIdle;
                    pop_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pop_seen_q <= 1'b0;
            tx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pop_seen_q <= pop_seen_d;
            tx_drop_q  <= tx_drop_d;
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: reset, RX interrupt handshake, RX full,
// TX backpressure and overflow, same-cycle events and pointer wrap.
module tb_io_port_controller;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] dev_in_data;
    logic        dev_in_valid;
    logic        dev_in_ready;
    logic [15:0] proc_in;
    logic        proc_in_rd;
    logic [15:0] proc_out;
    logic        proc_out_we;
    logic [15:0] dev_out_data;
    logic        dev_out_valid;
    logic        dev_out_ready;
    logic        int_req;
    logic        tx_drop;

    int n_checks = 0;
    int n_pass   = 0;

    io_port_controller #(
        .DATA_W    (16),
        .DEPTH     (4),
        .INT_PULSE (2)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .dev_in_data   (dev_in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .proc_in       (proc_in),
        .proc_in_rd    (proc_in_rd),
        .proc_out      (proc_out),
        .proc_out_we   (proc_out_we),
        .dev_out_data  (dev_out_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .int_req       (int_req),
        .tx_drop       (tx_drop)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [15:0] tx_exp [4];

    initial begin
        Rst = 1'b1;
        dev_in_data = '0; dev_in_valid = 1'b0; proc_in_rd = 1'b0;
        proc_out = '0; proc_out_we = 1'b0; dev_out_ready = 1'b0;
        tick(); tick();
        Rst = 1'b0;

        // T1: reset in the middle of traffic
        dev_in_valid = 1'b1; dev_in_data = 16'h1234;
        proc_out_we = 1'b1; proc_out = 16'h5555;
        tick();
        dev_in_valid = 1'b0; proc_out_we = 1'b0;
        tick();
        Rst = 1'b1;
        tick(); tick();
        Rst = 1'b0;
        check_eq("t1_int_req", int_req, 0);
        check_eq("t1_dev_out_valid", dev_out_valid, 0);
        check_eq("t1_proc_in", proc_in, 0);
        check_eq("t1_dev_in_ready", dev_in_ready, 1);
        check_eq("t1_tx_drop", tx_drop, 0);
        tick();
        check_eq("t1_int_idle", int_req, 0);

        // T2: single RX word, two-cycle interrupt pulse, pop
        dev_in_valid = 1'b1; dev_in_data = 16'hA5A5;
        tick();
        dev_in_valid = 1'b0;
        check_eq("t2_proc_in", proc_in, 16'hA5A5);
        check_eq("t2_int_c0", int_req, 0);
        tick();
        check_eq("t2_int_c1", int_req, 1);
        tick();
        check_eq("t2_int_c2", int_req, 1);
        tick();
        check_eq("t2_int_c3", int_req, 0);
        proc_in_rd = 1'b1;
        tick();
        proc_in_rd = 1'b0;
        check_eq("t2_proc_in_pop", proc_in, 0);
        tick();
        check_eq("t2_int_after", int_req, 0);

        // T3: fill RX, refuse 5th word, pop in order with re-interrupts
        for (int i = 1; i <= 4; i++) begin
            dev_in_valid = 1'b1; dev_in_data = 16'(i);
            tick();
        end
        check_eq("t3_ready_full", dev_in_ready, 0);
        dev_in_data = 16'h0005;
        tick();
        dev_in_valid = 1'b0;
        check_eq("t3_ready_still", dev_in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t3_head%0d", i), proc_in, 32'(i + 1));
            proc_in_rd = 1'b1;
            tick();
            proc_in_rd = 1'b0;
            check_eq($sformatf("t3_int_idle%0d", i), int_req, 0);
            tick();
            check_eq($sformatf("t3_reint%0d", i), int_req, (i < 3) ? 32'd1 : 32'd0);
            tick(); tick();
            check_eq($sformatf("t3_int_wait%0d", i), int_req, 0);
        end
        check_eq("t3_empty", proc_in, 0);
        check_eq("t3_ready_empty", dev_in_ready, 1);

        // T4: TX backpressure then drain
        tx_exp[0] = 16'h1111; tx_exp[1] = 16'h2222; tx_exp[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            proc_out_we = 1'b1; proc_out = tx_exp[i];
            tick();
        end
        proc_out_we = 1'b0;
        check_eq("t4_valid", dev_out_valid, 1);
        check_eq("t4_hold0", dev_out_data, 16'h1111);
        tick();
        check_eq("t4_hold1", dev_out_data, 16'h1111);
        dev_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t4_valid%0d", i), dev_out_valid, 1);
            check_eq($sformatf("t4_data%0d", i), dev_out_data, tx_exp[i]);
            tick();
        end
        check_eq("t4_drained", dev_out_valid, 0);
        dev_out_ready = 1'b0;

        // T5: TX overflow, then full + write + pop in one cycle
        for (int i = 1; i <= 5; i++) begin
            proc_out_we = 1'b1; proc_out = 16'hB000 + 16'(i);
            tick();
            if (i == 4) check_eq("t5_no_drop_yet", tx_drop, 0);
        end
        proc_out_we = 1'b0;
        check_eq("t5_drop", tx_drop, 1);
        check_eq("t5_head", dev_out_data, 16'hB001);
        proc_out_we = 1'b1; proc_out = 16'hB006; dev_out_ready = 1'b1;
        tick();
        proc_out_we = 1'b0;
        tx_exp[0] = 16'hB002; tx_exp[1] = 16'hB003; tx_exp[2] = 16'hB004; tx_exp[3] = 16'hB006;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t5_data%0d", i), dev_out_data, tx_exp[i]);
            tick();
        end
        check_eq("t5_drained", dev_out_valid, 0);
        check_eq("t5_drop_sticky", tx_drop, 1);
        dev_out_ready = 1'b0;

        // T6a: read strobe on empty RX with same-cycle push
        dev_in_valid = 1'b1; dev_in_data = 16'hC0DE; proc_in_rd = 1'b1;
        tick();
        dev_in_valid = 1'b0; proc_in_rd = 1'b0;
        check_eq("t6_retained", proc_in, 16'hC0DE);
        tick();
        check_eq("t6_pulse_start", int_req, 1);
        // Pop during the pulse: pulse keeps its length, FSM must not wait for a second pop.
        proc_in_rd = 1'b1;
        tick();
        proc_in_rd = 1'b0;
        check_eq("t6_pulse_full", int_req, 1);
        check_eq("t6_popped", proc_in, 0);
        tick();
        check_eq("t6_pulse_end", int_req, 0);
        dev_in_valid = 1'b1; dev_in_data = 16'hC0DF;
        tick();
        dev_in_valid = 1'b0;
        tick();
        check_eq("t6_pop_seen_reint", int_req, 1);
        proc_in_rd = 1'b1;
        tick();
        proc_in_rd = 1'b0;
        check_eq("t6_empty", proc_in, 0);

        // T6b: pointer wrap with simultaneous push/pop
        dev_in_valid = 1'b1; dev_in_data = 16'hD000;
        tick();
        for (int i = 1; i <= 10; i++) begin
            check_eq($sformatf("t6_wrap%0d", i), proc_in, 32'(16'hD000 + 16'(i - 1)));
            dev_in_data = 16'hD000 + 16'(i); proc_in_rd = 1'b1;
            tick();
        end
        dev_in_valid = 1'b0;
        check_eq("t6_wrap_last", proc_in, 16'hD00A);
        tick();
        proc_in_rd = 1'b0;
        check_eq("t6_wrap_empty", proc_in, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
